// File: rtl/galaxian_pkg.sv
// Shared definitions for the galaxian game logic: default geometry,
// scheduling timing and the enemy attack scheduler state encoding.
package galaxian_pkg;

    localparam int NUM_ENEMIES_DEF     = 24;
    localparam int ENEMY_SIZE_DEF      = 16;
    localparam int COOLDOWN_FRAMES_DEF = 32;
    localparam int POS_W               = 10;
    localparam int ID_W                = 5;

    typedef enum logic [1:0] {
        SCHED_IDLE     = 2'd0,
        SCHED_COOLDOWN = 2'd1,
        SCHED_SEARCH   = 2'd2,
        SCHED_OFFER    = 2'd3
    } sched_state_e;

endpackage

// File: rtl/enemy_attack_scheduler_rr_find_next.sv
// Round-robin picker: returns the first present enemy after ptr,
// wrapping from the last slot back to slot 0 and ending at ptr itself.
module rr_find_next
    import galaxian_pkg::*;
#(
    parameter int N  = NUM_ENEMIES_DEF,
    parameter int IW = ID_W
) (
    input  logic [N-1:0]  present,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk candidates from farthest to nearest so the nearest present one wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (present[IW'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/enemy_attack_scheduler.sv
// Enemy attack scheduler: after a cooldown, picks the next living enemy
// round-robin and offers a missile launch from below its sprite.
module enemy_attack_scheduler
    import galaxian_pkg::*;
#(
    parameter int NUM_ENEMIES     = NUM_ENEMIES_DEF,
    parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
    parameter int ENEMY_SIZE      = ENEMY_SIZE_DEF
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   level,
    input  logic                   lost_game,
    input  logic [NUM_ENEMIES-1:0] enemy_present,
    input  logic [POS_W-1:0]       enemy_posX [NUM_ENEMIES],
    input  logic [POS_W-1:0]       enemy_posY [NUM_ENEMIES],
    output logic                   launch_valid,
    input  logic                   launch_ready,
    output logic [ID_W-1:0]        launch_id,
    output logic [POS_W-1:0]       launch_x,
    output logic [POS_W-1:0]       launch_y,
    output logic [ID_W-1:0]        enemies_remaining,
    output logic                   all_cleared
);

    localparam int              CD_W     = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [CD_W-1:0] CD_LOAD  = CD_W'(COOLDOWN_FRAMES - 1);
    localparam logic [ID_W-1:0] PTR_INIT = ID_W'(NUM_ENEMIES - 1);
    localparam logic [POS_W-1:0] X_OFS   = POS_W'(ENEMY_SIZE / 2);
    localparam logic [POS_W-1:0] Y_OFS   = POS_W'(ENEMY_SIZE);

    function automatic logic [ID_W-1:0] popcount(input logic [NUM_ENEMIES-1:0] v);
        logic [ID_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            n = n + ID_W'(v[i]);
        end
        return n;
    endfunction

    sched_state_e      state_q, state_d;
    logic [CD_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   launch_id_q, launch_id_d;
    logic [POS_W-1:0]  launch_x_q, launch_x_d;
    logic [POS_W-1:0]  launch_y_q, launch_y_d;
    logic              launch_valid_q, launch_valid_d;
    logic [ID_W-1:0]   remaining_q, remaining_d;
    logic              cleared_q, cleared_d;

    logic              enable;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;

    assign enable = level & ~lost_game;

    rr_find_next #(
        .N  (NUM_ENEMIES),
        .IW (ID_W)
    ) u_rr_find_next (
        .present (enemy_present),
        .ptr     (ptr_q),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // State and output registers; async reset also drops an in-flight offer at once.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q        <= SCHED_IDLE;
            cnt_q          <= '0;
            ptr_q          <= PTR_INIT;
            launch_id_q    <= '0;
            launch_x_q     <= '0;
            launch_y_q     <= '0;
            launch_valid_q <= 1'b0;
            remaining_q    <= '0;
            cleared_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            launch_id_q    <= launch_id_d;
            launch_x_q     <= launch_x_d;
            launch_y_q     <= launch_y_d;
            launch_valid_q <= launch_valid_d;
            remaining_q    <= remaining_d;
            cleared_q      <= cleared_d;
        end
    end

    // Next-state: acceptance outranks withdrawal when the target dies on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (!enable) begin
            state_d = SCHED_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SCHED_IDLE: begin
                    state_d = SCHED_COOLDOWN;
                    cnt_d   = CD_LOAD;
                end
                SCHED_COOLDOWN: begin
                    if (cnt_q == '0) begin
                        state_d = SCHED_SEARCH;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SCHED_SEARCH: begin
                    if (pick_found) begin
                        state_d = SCHED_OFFER;
                    end else begin
                        state_d = SCHED_SEARCH;
                    end
                end
                SCHED_OFFER: begin
                    if (launch_ready) begin
                        state_d = SCHED_COOLDOWN;
                        cnt_d   = CD_LOAD;
                        ptr_d   = launch_id_q;
                    end else if (!enemy_present[launch_id_q]) begin
                        state_d = SCHED_SEARCH;
                    end else begin
                        state_d = SCHED_OFFER;
                    end
                end
                default: begin
                    state_d = SCHED_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values: launch fields latch only on a successful search and hold otherwise.
    always_comb begin
        launch_valid_d = (state_d == SCHED_OFFER);
        remaining_d    = popcount(enemy_present);
        cleared_d      = enable & (remaining_q == '0);
        if (!enable) begin
            launch_id_d = '0;
            launch_x_d  = '0;
            launch_y_d  = '0;
        end else if ((state_q == SCHED_SEARCH) && pick_found) begin
            launch_id_d = pick_idx;
            launch_x_d  = enemy_posX[pick_idx] + X_OFS;
            launch_y_d  = enemy_posY[pick_idx] + Y_OFS;
        end else begin
            launch_id_d = launch_id_q;
            launch_x_d  = launch_x_q;
            launch_y_d  = launch_y_q;
        end
    end

    assign launch_valid      = launch_valid_q;
    assign launch_id         = launch_id_q;
    assign launch_x          = launch_x_q;
    assign launch_y          = launch_y_q;
    assign enemies_remaining = remaining_q;
    assign all_cleared       = cleared_q;

endmodule

// File: tb/tb_enemy_attack_scheduler.sv
// Self-checking bench for enemy_attack_scheduler: directed scenarios plus
// randomized play compared cycle by cycle against a behavioural model.
module tb_enemy_attack_scheduler;
    import galaxian_pkg::*;

    localparam int N  = 24;
    localparam int CD = 32;
    localparam int ES = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_HUNT  = 2;
    localparam int PH_OFFER = 3;

    logic          frame_clk = 1'b0;
    logic          Reset = 1'b0;
    logic          level = 1'b0;
    logic          lost_game = 1'b0;
    logic          launch_ready = 1'b0;
    logic [N-1:0]  enemy_present = '0;
    logic [9:0]    enemy_posX [N];
    logic [9:0]    enemy_posY [N];
    logic          launch_valid;
    logic [4:0]    launch_id;
    logic [9:0]    launch_x;
    logic [9:0]    launch_y;
    logic [4:0]    enemies_remaining;
    logic          all_cleared;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: phase, absolute frame of next search, last picked target
    int m_phase, m_cyc, m_search_at, m_ptr, m_id, m_x, m_y, m_rem;
    bit m_valid, m_clr;

    always #5 frame_clk = ~frame_clk;

    enemy_attack_scheduler #(
        .NUM_ENEMIES     (N),
        .COOLDOWN_FRAMES (CD),
        .ENEMY_SIZE      (ES)
    ) dut (
        .frame_clk         (frame_clk),
        .Reset             (Reset),
        .level             (level),
        .lost_game         (lost_game),
        .enemy_present     (enemy_present),
        .enemy_posX        (enemy_posX),
        .enemy_posY        (enemy_posY),
        .launch_valid      (launch_valid),
        .launch_ready      (launch_ready),
        .launch_id         (launch_id),
        .launch_x          (launch_x),
        .launch_y          (launch_y),
        .enemies_remaining (enemies_remaining),
        .all_cleared       (all_cleared)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_search_at = 0;
        m_ptr = N - 1;
        m_id = 0; m_x = 0; m_y = 0;
        m_valid = 1'b0; m_rem = 0; m_clr = 1'b0;
    endtask

    // One frame edge of the game rules, using the inputs currently driven.
    task automatic model_step();
        bit en;
        int new_rem;
        bit new_clr;
        m_cyc++;
        en = level && !lost_game;
        new_rem = $countones(enemy_present);
        new_clr = en && (m_rem == 0);
        if (!en) begin
            m_phase = PH_IDLE;
            m_id = 0; m_x = 0; m_y = 0;
        end else begin
            case (m_phase)
                PH_IDLE: begin
                    m_phase = PH_WAIT;
                    m_search_at = m_cyc + CD;
                end
                PH_WAIT: if (m_cyc == m_search_at) m_phase = PH_HUNT;
                PH_HUNT: begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (enemy_present[c]) begin
                            m_id = c;
                            m_x = (int'(enemy_posX[c]) + ES / 2) % 1024;
                            m_y = (int'(enemy_posY[c]) + ES) % 1024;
                            m_phase = PH_OFFER;
                            break;
                        end
                    end
                end
                PH_OFFER: begin
                    if (launch_ready) begin
                        m_ptr = m_id;
                        m_phase = PH_WAIT;
                        m_search_at = m_cyc + CD;
                    end else if (!enemy_present[m_id]) begin
                        m_phase = PH_HUNT;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        m_valid = (m_phase == PH_OFFER);
        m_rem = new_rem;
        m_clr = new_clr;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".valid"}, 32'(launch_valid), 32'(m_valid));
        check_eq({tag, ".id"}, 32'(launch_id), 32'(m_id));
        check_eq({tag, ".x"}, 32'(launch_x), 32'(m_x));
        check_eq({tag, ".y"}, 32'(launch_y), 32'(m_y));
        check_eq({tag, ".remaining"}, 32'(enemies_remaining), 32'(m_rem));
        check_eq({tag, ".cleared"}, 32'(all_cleared), 32'(m_clr));
    endtask

    task automatic run_cycle();
        model_step();
        @(negedge frame_clk);
        check_outputs("cyc");
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is visible before any edge.
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge frame_clk);
        check_outputs("rst_held");
        Reset = 1'b0;
    endtask

    task automatic wait_offer(input int max_cycles);
        int k;
        k = 0;
        while (!launch_valid && k < max_cycles) begin
            run_cycle();
            k++;
        end
        check_eq("offer_seen", 32'(launch_valid), 32'd1);
    endtask

    initial begin
        int nl;
        int ids [4];
        int ts [4];
        m_cyc = 0;
        for (int i = 0; i < N; i++) begin
            enemy_posX[i] = 10'd0;
            enemy_posY[i] = 10'd0;
        end
        model_reset();
        #2;
        do_reset();

        // Single living enemy: launch point below sprite centre
        enemy_present = '0;
        enemy_present[5] = 1'b1;
        enemy_posX[5] = 10'd133;
        enemy_posY[5] = 10'd48;
        level = 1'b1;
        wait_offer(80);
        check_eq("pick5_id", 32'(launch_id), 32'd5);
        check_eq("pick5_x", 32'(launch_x), 32'd141);
        check_eq("pick5_y", 32'(launch_y), 32'd64);
        repeat (10) run_cycle();
        check_eq("hold_valid", 32'(launch_valid), 32'd1);
        check_eq("hold_id", 32'(launch_id), 32'd5);
        launch_ready = 1'b1;
        run_cycle();
        launch_ready = 1'b0;
        check_eq("accept_drop", 32'(launch_valid), 32'd0);

        // Launch point wraps modulo 1024
        enemy_present = '0;
        enemy_present[7] = 1'b1;
        enemy_posX[7] = 10'd1020;
        enemy_posY[7] = 10'd1010;
        wait_offer(80);
        check_eq("wrap_id", 32'(launch_id), 32'd7);
        check_eq("wrap_x", 32'(launch_x), 32'd4);
        check_eq("wrap_y", 32'(launch_y), 32'd2);

        // Withdraw on target death, then accept beats death on the same edge
        do_reset();
        enemy_present = '1;
        wait_offer(80);
        check_eq("first_id", 32'(launch_id), 32'd0);
        enemy_present[0] = 1'b0;
        run_cycle();
        check_eq("withdraw_drop", 32'(launch_valid), 32'd0);
        wait_offer(10);
        check_eq("after_withdraw_id", 32'(launch_id), 32'd1);
        enemy_present[1] = 1'b0;
        launch_ready = 1'b1;
        run_cycle();
        launch_ready = 1'b0;
        check_eq("accept_on_death", 32'(launch_valid), 32'd0);
        wait_offer(80);
        check_eq("after_accept_id", 32'(launch_id), 32'd2);

        // Lost game suspends scheduling; clearing the board raises all_cleared a cycle later
        lost_game = 1'b1;
        run_cycle();
        check_eq("lost_drop", 32'(launch_valid), 32'd0);
        lost_game = 1'b0;
        enemy_present = '0;
        run_cycle();
        check_eq("cleared_count", 32'(enemies_remaining), 32'd0);
        check_eq("cleared_early", 32'(all_cleared), 32'd0);
        run_cycle();
        check_eq("cleared_flag", 32'(all_cleared), 32'd1);
        repeat (50) run_cycle();

        // Full formation, ready tied high: ids 0,1,2,3 every 34 frames
        do_reset();
        enemy_present = '1;
        launch_ready = 1'b1;
        nl = 0;
        for (int c = 0; c < 200 && nl < 4; c++) begin
            if (launch_valid) begin
                ids[nl] = int'(launch_id);
                ts[nl] = c;
                nl++;
            end
            run_cycle();
        end
        check_eq("rr_launches", 32'(nl), 32'd4);
        for (int i = 0; i < nl; i++) begin
            check_eq("rr_id", 32'(ids[i]), 32'(i));
            if (i > 0) check_eq("rr_period", 32'(ts[i] - ts[i-1]), 32'd34);
        end
        launch_ready = 1'b0;

        // Randomized play
        do_reset();
        enemy_present = N'($urandom);
        for (int i = 0; i < N; i++) begin
            enemy_posX[i] = 10'($urandom_range(0, 1023));
            enemy_posY[i] = 10'($urandom_range(0, 1023));
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int idx;
            if ($urandom_range(0, 199) == 0) level = ~level;
            lost_game = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 79) == 0) enemy_present[i] = ~enemy_present[i];
            end
            if ($urandom_range(0, 499) == 0) enemy_present = '0;
            if ($urandom_range(0, 299) == 0) enemy_present = '1;
            launch_ready = ($urandom_range(0, 3) == 0);
            idx = $urandom_range(0, N - 1);
            enemy_posX[idx] = 10'($urandom_range(0, 1023));
            enemy_posY[idx] = 10'($urandom_range(0, 1023));
            run_cycle();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
